instr_encoder: RTL and testbench

- Pipelined RISC-V RV32I instruction encoder; inverse of the immediate generator.
- Accepts decoded fields: opcode, registers, funct3/funct7 and a sign-extended 32-bit immediate.
- Range-checks the immediate for the target format, scatters it into the instruction bit positions, and emits the 32-bit word.
- Used by the instruction-memory loader and by the self-check bench: each encoded word is fed back through immediate decode.

---
 rtl/instr_encoder_if.sv | 32 +++
 rtl/instr_encoder.sv | 141 ++++++++++++++
 tb/tb_instr_encoder.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Field/word handshake bundle for the RV32I instruction encoder.
// master drives fields and accepts words; slave is the encoder.
interface instr_encoder_if #(
    parameter int unsigned CNT_W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [4:0]       opcode_i;
    logic [4:0]       rd_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic [2:0]       funct3_i;
    logic [6:0]       funct7_i;
    logic [31:0]      imm_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      instr_o;
    logic             err_o;
    logic [CNT_W-1:0] err_cnt_o;

    modport master (
        output in_valid_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
        output out_ready_i,
        input  in_ready_o, out_valid_o, instr_o, err_o, err_cnt_o
    );

    modport slave (
        input  in_valid_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i,
        input  out_ready_i,
        output in_ready_o, out_valid_o, instr_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/instr_encoder.sv
// Two-stage RV32I instruction encoder: range-checks the immediate in S1,
// scatters it into the instruction word in S2, counts erroneous words.
module instr_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input logic            clk_i,
    input logic            rst_ni,
    instr_encoder_if.slave bus
);

    localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
    localparam logic [4:0] OPCODE_OP_IMM = 5'b00100;
    localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
    localparam logic [4:0] OPCODE_STORE  = 5'b01000;
    localparam logic [4:0] OPCODE_OP     = 5'b01100;
    localparam logic [4:0] OPCODE_LUI    = 5'b01101;
    localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
    localparam logic [4:0] OPCODE_JALR   = 5'b11001;
    localparam logic [4:0] OPCODE_JAL    = 5'b11011;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

    // 1 when the opcode is illegal or the immediate does not fit its format
    function automatic logic imm_err(input logic [4:0] op, input logic [2:0] f3,
                                     input logic [31:0] x);
        logic err;
        logic i_bad;
        i_bad = (x[31:11] != {21{x[11]}});
        err   = 1'b1;
        case (op)
            OPCODE_LUI, OPCODE_AUIPC:              err = (x[11:0] != 12'h000);
            OPCODE_JAL:                            err = (x[31:20] != {12{x[20]}}) | x[0];
            OPCODE_JALR, OPCODE_LOAD, OPCODE_STORE: err = i_bad;
            OPCODE_OP_IMM:                         err = is_shift(f3) ? (x[31:5] != 27'd0) : i_bad;
            OPCODE_BRANCH:                         err = (x[31:12] != {20{x[12]}}) | x[0];
            OPCODE_OP:                             err = 1'b0;
            default:                               err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [31:0] pack(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [31:0] x);
        logic [31:0] w;
        logic [6:0]  o;
        o = {op, 2'b11};
        w = 32'h0000_0000;
        case (op)
            OPCODE_LUI, OPCODE_AUIPC: w = {x[31:12], rd, o};
            OPCODE_JAL:               w = {x[20], x[10:1], x[11], x[19:12], rd, o};
            OPCODE_JALR, OPCODE_LOAD: w = {x[11:0], rs1, f3, rd, o};
            OPCODE_OP_IMM:            w = is_shift(f3) ? {f7, x[4:0], rs1, f3, rd, o}
                                                       : {x[11:0], rs1, f3, rd, o};
            OPCODE_BRANCH:            w = {x[12], x[10:5], rs2, rs1, f3, x[4:1], x[11], o};
            OPCODE_STORE:             w = {x[11:5], rs2, rs1, f3, x[4:0], o};
            OPCODE_OP:                w = {f7, rs2, rs1, f3, rd, o};
            default:                  w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    logic             s1_valid;
    logic [4:0]       s1_op;
    logic [4:0]       s1_rd;
    logic [4:0]       s1_rs1;
    logic [4:0]       s1_rs2;
    logic [2:0]       s1_f3;
    logic [6:0]       s1_f7;
    logic [31:0]      s1_imm;
    logic             s1_err;

    logic             s2_valid;
    logic [31:0]      s2_instr;
    logic             s2_err;
    logic [CNT_W-1:0] err_cnt_q;

    logic s2_adv_c;
    logic in_fire_c;
    logic out_fire_c;

    assign s2_adv_c   = !s2_valid || bus.out_ready_i;
    assign in_fire_c  = bus.in_valid_i && bus.in_ready_o;
    assign out_fire_c = s2_valid && bus.out_ready_i;

    assign bus.in_ready_o  = rst_ni && (!s1_valid || s2_adv_c);
    assign bus.out_valid_o = s2_valid;
    assign bus.instr_o     = s2_instr;
    assign bus.err_o       = s2_err;
    assign bus.err_cnt_o   = err_cnt_q;

    // S1 payload: captured fields plus the range verdict
    always_ff @(posedge clk_i) begin
        if (in_fire_c) begin
            s1_op  <= bus.opcode_i;
            s1_rd  <= bus.rd_i;
            s1_rs1 <= bus.rs1_i;
            s1_rs2 <= bus.rs2_i;
            s1_f3  <= bus.funct3_i;
            s1_f7  <= bus.funct7_i;
            s1_imm <= bus.imm_i;
            s1_err <= imm_err(bus.opcode_i, bus.funct3_i, bus.imm_i);
        end
    end

    // Stage valids, S2 word and the saturating error counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s2_instr  <= 32'h0000_0000;
            s2_err    <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            if (in_fire_c) begin
                s1_valid <= 1'b1;
            end else if (s2_adv_c) begin
                s1_valid <= 1'b0;
            end

            if (s2_adv_c) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_instr <= s1_err ? 32'h0000_0000
                                       : pack(s1_op, s1_rd, s1_rs1, s1_rs2, s1_f3, s1_f7, s1_imm);
                    s2_err   <= s1_err;
                end
            end

            if (out_fire_c && s2_err && (err_cnt_q != CNT_MAX)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed encodes, range errors,
// backpressure, mid-stream reset, counter saturation and a randomized stream.
module tb_instr_encoder;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [4:0]  op;
        logic [2:0]  f3;
        logic [31:0] imm;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_encoder_if #(.CNT_W(16)) bus ();
    instr_encoder_if #(.CNT_W(2))  sbus ();

    instr_encoder #(.CNT_W(16)) u_dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));
    instr_encoder #(.CNT_W(2))  u_sat (.clk_i(clk), .rst_ni(rst_n), .bus(sbus.slave));

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    bit          in_f;
    bit          out_f;
    bit          hold_valid;
    logic [31:0] hold_instr;
    logic        hold_err;
    logic [15:0] exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: range rules as signed arithmetic, word as the field layout
    function automatic exp_t ref_model(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       input logic [31:0] x);
        exp_t e;
        int   s;
        bit   ok;
        logic [6:0] o;
        s = $signed(x);
        o = {op, 2'b11};
        e.op = op; e.f3 = f3; e.imm = x; e.instr = 32'h0;
        ok = 1'b1;
        case (op)
            5'b01101, 5'b00101: begin
                ok = (x % 32'd4096) == 32'd0;
                e.instr = {x[31:12], rd, o};
            end
            5'b11011: begin
                ok = (s >= -1048576) && (s <= 1048575) && (x[0] == 1'b0);
                e.instr = {x[20], x[10:1], x[11], x[19:12], rd, o};
            end
            5'b11001, 5'b00000: begin
                ok = (s >= -2048) && (s <= 2047);
                e.instr = {x[11:0], rs1, f3, rd, o};
            end
            5'b00100: begin
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    ok = x < 32'd32;
                    e.instr = {f7, x[4:0], rs1, f3, rd, o};
                end else begin
                    ok = (s >= -2048) && (s <= 2047);
                    e.instr = {x[11:0], rs1, f3, rd, o};
                end
            end
            5'b11000: begin
                ok = (s >= -4096) && (s <= 4095) && (x[0] == 1'b0);
                e.instr = {x[12], x[10:5], rs2, rs1, f3, x[4:1], x[11], o};
            end
            5'b01000: begin
                ok = (s >= -2048) && (s <= 2047);
                e.instr = {x[11:5], rs2, rs1, f3, x[4:0], o};
            end
            5'b01100: e.instr = {f7, rs2, rs1, f3, rd, o};
            default:  ok = 1'b0;
        endcase
        if (!ok) e.instr = 32'h0;
        e.err = !ok;
        return e;
    endfunction

    // Immediate decode of an encoded word, used as the round-trip check
    function automatic logic [31:0] imm_decode(input logic [31:0] w, input logic [4:0] op,
                                               input logic [2:0] f3);
        logic [31:0] r;
        r = 32'h0;
        case (op)
            5'b01101, 5'b00101: r = {w[31:12], 12'h000};
            5'b11011:           r = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            5'b11001, 5'b00000: r = {{20{w[31]}}, w[31:20]};
            5'b00100:           r = (f3 == 3'b001 || f3 == 3'b101) ? {27'h0, w[24:20]}
                                                                 : {{20{w[31]}}, w[31:20]};
            5'b11000:           r = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            5'b01000:           r = {{20{w[31]}}, w[31:25], w[11:7]};
            default:            r = 32'h0;
        endcase
        return r;
    endfunction

    // One clock: observe transfers at negedge, score them, return #1 after posedge
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        in_f  = rst_n && bus.in_valid_i && bus.in_ready_o;
        out_f = rst_n && bus.out_valid_o && bus.out_ready_i;
        if (rst_n) begin
            if (hold_valid) begin
                chk("hold_valid", 32'(bus.out_valid_o), 32'd1);
                chk("hold_instr", bus.instr_o, hold_instr);
                chk("hold_err", 32'(bus.err_o), 32'(hold_err));
            end
            hold_valid = bus.out_valid_o && !bus.out_ready_i;
            hold_instr = bus.instr_o;
            hold_err   = bus.err_o;
            if (out_f) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_instr", bus.instr_o, e.instr);
                    chk("sb_err", 32'(bus.err_o), 32'(e.err));
                    if (!e.err && e.op != 5'b01100)
                        chk("sb_imm_roundtrip", imm_decode(bus.instr_o, e.op, e.f3), e.imm);
                    if (e.err && exp_cnt != 16'hFFFF) exp_cnt++;
                end
            end
            if (in_f)
                exp_q.push_back(ref_model(bus.opcode_i, bus.rd_i, bus.rs1_i, bus.rs2_i,
                                          bus.funct3_i, bus.funct7_i, bus.imm_i));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] imm);
        bus.opcode_i = op; bus.rd_i = rd; bus.rs1_i = rs1; bus.rs2_i = rs2;
        bus.funct3_i = f3; bus.funct7_i = f7; bus.imm_i = imm;
        bus.in_valid_i = 1'b1;
    endtask

    task automatic rand_fields();
        logic [4:0]  ops [10];
        logic [11:0] t12;
        logic [12:0] t13;
        logic [20:0] t21;
        ops = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11111};
        bus.opcode_i = ops[$urandom_range(0, 9)];
        bus.rd_i     = 5'($urandom);
        bus.rs1_i    = 5'($urandom);
        bus.rs2_i    = 5'($urandom);
        bus.funct3_i = 3'($urandom);
        bus.funct7_i = 7'($urandom);
        case ($urandom_range(0, 5))
            0: bus.imm_i = $urandom;
            1: begin t12 = 12'($urandom); bus.imm_i = {{20{t12[11]}}, t12}; end
            2: begin t13 = 13'($urandom); t13[0] = 1'b0; bus.imm_i = {{19{t13[12]}}, t13}; end
            3: begin t21 = 21'($urandom); t21[0] = 1'b0; bus.imm_i = {{11{t21[20]}}, t21}; end
            4: bus.imm_i = $urandom & 32'hFFFF_F000;
            default: bus.imm_i = 32'($urandom_range(0, 40));
        endcase
    endtask

    // Single encode with out_ready=1: latency, word, err and counter
    task automatic shot(input string tag, input logic [4:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm,
                        input logic [31:0] exp_w, input logic exp_e);
        drive(op, rd, rs1, rs2, f3, f7, imm);
        bus.out_ready_i = 1'b1;
        cycle();
        chk({tag, "_accept"}, 32'(in_f), 32'd1);
        bus.in_valid_i = 1'b0;
        chk({tag, "_not_yet"}, 32'(bus.out_valid_o), 32'd0);
        cycle();
        chk({tag, "_valid"}, 32'(bus.out_valid_o), 32'd1);
        chk({tag, "_word"}, bus.instr_o, exp_w);
        chk({tag, "_err"}, 32'(bus.err_o), 32'(exp_e));
        cycle();
        chk({tag, "_cnt"}, 32'(bus.err_cnt_o), 32'(exp_cnt));
    endtask

    initial begin
        int acc;
        int nout;
        int first_c;
        int last_c;
        int sent;
        int cyc;

        rst_n = 1'b0;
        hold_valid = 1'b0;
        exp_cnt = 16'h0;
        drive(5'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0);
        bus.in_valid_i = 1'b0;
        bus.out_ready_i = 1'b1;
        sbus.in_valid_i = 1'b0; sbus.out_ready_i = 1'b1;
        sbus.opcode_i = 5'h0; sbus.rd_i = 5'h0; sbus.rs1_i = 5'h0; sbus.rs2_i = 5'h0;
        sbus.funct3_i = 3'h0; sbus.funct7_i = 7'h0; sbus.imm_i = 32'h0;

        cycle();
        cycle();
        chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        chk("rst_instr", bus.instr_o, 32'h0);
        chk("rst_err", 32'(bus.err_o), 32'd0);
        chk("rst_cnt", 32'(bus.err_cnt_o), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
        chk("rst_sat_cnt", 32'(sbus.err_cnt_o), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(bus.in_ready_o), 32'd1);

        shot("addi", 5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
        shot("lui",  5'b01101, 5'd5, 5'd0, 5'd0, 3'b000, 7'h0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        shot("jal",  5'b11011, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0, 32'd8,         32'h0080_00EF, 1'b0);
        shot("beq",  5'b11000, 5'd0, 5'd1, 5'd2, 3'b000, 7'h0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        shot("sw",   5'b01000, 5'd0, 5'd1, 5'd2, 3'b010, 7'h0, 32'd8,         32'h0020_A423, 1'b0);
        shot("srai", 5'b00100, 5'd1, 5'd1, 5'd0, 3'b101, 7'b0100000, 32'd3,   32'h4030_D093, 1'b0);

        shot("e_addi", 5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0, 32'd2048, 32'h0, 1'b1);
        shot("e_beq",  5'b11000, 5'd0, 5'd1, 5'd2, 3'b000, 7'h0, 32'd3,    32'h0, 1'b1);
        shot("e_lui",  5'b01101, 5'd5, 5'd0, 5'd0, 3'b000, 7'h0, 32'd1,    32'h0, 1'b1);
        shot("e_op",   5'b11111, 5'd1, 5'd2, 5'd3, 3'b000, 7'h0, 32'd0,    32'h0, 1'b1);
        chk("err_cnt_four", 32'(bus.err_cnt_o), 32'd4);

        // Backpressure: stall 4 cycles, then release a 5-word stream
        bus.out_ready_i = 1'b0;
        acc = 0;
        rand_fields();
        bus.in_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (in_f) begin
                acc++;
                if (acc < 5) rand_fields(); else bus.in_valid_i = 1'b0;
            end
        end
        chk("bp_accepted", 32'(acc), 32'd2);
        chk("bp_in_ready_low", 32'(bus.in_ready_o), 32'd0);
        bus.out_ready_i = 1'b1;
        nout = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 40 && (acc < 5 || exp_q.size() != 0); c++) begin
            cycle();
            if (in_f) begin
                acc++;
                if (acc < 5) rand_fields(); else bus.in_valid_i = 1'b0;
            end
            if (out_f) begin
                if (first_c < 0) first_c = c;
                last_c = c;
                nout++;
            end
        end
        bus.in_valid_i = 1'b0;
        chk("bp_words_out", 32'(nout), 32'd5);
        chk("bp_rate", 32'(last_c - first_c), 32'd4);

        // Reset with two words buffered
        bus.out_ready_i = 1'b0;
        drive(5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0, 32'd5);
        cycle();
        drive(5'b11111, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0, 32'd0);
        cycle();
        bus.in_valid_i = 1'b0;
        chk("mid_cnt_nonzero", 32'(bus.err_cnt_o != 16'h0), 32'd1);
        rst_n = 1'b0;
        cycle();
        chk("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
        chk("mid_rst_cnt", 32'(bus.err_cnt_o), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready_o), 32'd0);
        exp_q.delete();
        exp_cnt = 16'h0;
        hold_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("mid_rel_in_ready", 32'(bus.in_ready_o), 32'd1);
        shot("post_rst", 5'b00100, 5'd1, 5'd0, 5'd0, 3'b000, 7'h0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);

        // Saturation on the 2-bit counter instance
        for (int k = 0; k < 5; k++) begin
            sbus.opcode_i = 5'b11111;
            sbus.in_valid_i = 1'b1;
            chk("sat_ready", 32'(sbus.in_ready_o), 32'd1);
            cycle();
            sbus.in_valid_i = 1'b0;
            cycle();
            chk("sat_valid", 32'(sbus.out_valid_o), 32'd1);
            chk("sat_err", 32'(sbus.err_o), 32'd1);
            cycle();
            chk("sat_cnt", 32'(sbus.err_cnt_o), 32'((k < 3) ? k + 1 : 3));
        end

        // Randomized stream with random backpressure
        sent = 0;
        cyc = 0;
        while ((sent < 300 || exp_q.size() != 0) && cyc < 5000) begin
            if (!bus.in_valid_i && sent < 300 && $urandom_range(0, 3) != 0) begin
                rand_fields();
                bus.in_valid_i = 1'b1;
            end
            bus.out_ready_i = ($urandom_range(0, 9) < 7);
            cycle();
            if (in_f) begin
                sent++;
                bus.in_valid_i = 1'b0;
            end
            cyc++;
        end
        chk("rand_drained", 32'(sent == 300 && exp_q.size() == 0), 32'd1);
        chk("rand_cnt", 32'(bus.err_cnt_o), 32'(exp_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
